card_draw_hex: RTL and testbench

// - Card source and display helpers for the 21 card game. Holds a free-running

---
 rtl/card_game_pkg.sv | 28 ++
 rtl/card_draw_hex_seg7.sv | 36 +++
 rtl/card_draw_hex.sv | 99 +++++++++
 tb/tb_card_draw_hex.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/card_game_pkg.sv
// card_game_pkg
// Shared constants for the 21 card game card source and HEX display helpers.
// Seven-segment patterns are active-low, bit[6:0] = g,f,e,d,c,b,a.
package card_game_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    // All segments off; reserved for a future blanking mode.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] CARD_MIN_DEF = 4'd1;
    localparam logic [3:0] CARD_MAX_DEF = 4'd13;

endpackage

// File: rtl/card_draw_hex_seg7.sv
// seg7_decoder
// Combinational hex nibble to active-low 7-segment pattern.
// Ports:
//   digit_i  in   4  nibble to display (0..F)
//   seg_o    out  7  pattern, bit[6:0] = g,f,e,d,c,b,a, active-low
module seg7_decoder
    import card_game_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/card_draw_hex.sv
// card_draw_hex
// Card source and HEX display helpers for the 21 card game. A free-running
// counter cycles CARD_MIN..CARD_MAX while draw is low and freezes while draw
// is high; each rising edge of draw latches the counter into card.
// Ports:
//   clock      in   1        system clock
//   reset      in   1        synchronous, active-high reset
//   draw       in   1        draw request level
//   card       out  4        latched card value, 0 = nothing drawn yet
//   dec_value  in   VALUE_W  unsigned value for the decimal display
//   hex_tens   out  7        7-seg pattern of the tens digit of dec_value
//   hex_ones   out  7        7-seg pattern of the ones digit of dec_value
//   code_in    in   4        raw hex nibble (turn/outcome codes)
//   hex_code   out  7        7-seg pattern of code_in
module card_draw_hex
    import card_game_pkg::*;
#(
    parameter logic [3:0] CARD_MIN = CARD_MIN_DEF,
    parameter logic [3:0] CARD_MAX = CARD_MAX_DEF,
    parameter int         VALUE_W  = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               draw,
    output logic [3:0]         card,
    input  logic [VALUE_W-1:0] dec_value,
    output logic [6:0]         hex_tens,
    output logic [6:0]         hex_ones,
    input  logic [3:0]         code_in,
    output logic [6:0]         hex_code
);

    logic [3:0] cnt_q, cnt_d;
    logic [3:0] card_q, card_d;
    logic       draw_prev_q;
    logic       draw_rise;

    assign draw_rise = draw & ~draw_prev_q;

    always_comb begin
        cnt_d  = cnt_q;
        card_d = card_q;
        // >= rather than == so an out-of-range value can only recover.
        if (!draw) begin
            cnt_d = (cnt_q >= CARD_MAX) ? CARD_MIN : cnt_q + 4'd1;
        end
        if (draw_rise) begin
            card_d = cnt_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q       <= CARD_MIN;
            card_q      <= 4'd0;
            draw_prev_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            card_q      <= card_d;
            draw_prev_q <= draw;
        end
    end

    assign card = card_q;

    // Divide/mod by 10 as a compare chain; cheap for the small score range.
    // Assumes dec_value stays below 100 so the tens digit fits one display.
    localparam int MAX_TENS = ((2 ** VALUE_W) - 1) / 10;

    logic [3:0] tens_digit;
    logic [3:0] ones_digit;

    always_comb begin
        tens_digit = 4'd0;
        ones_digit = 4'(32'(dec_value));
        for (int t = 1; t <= MAX_TENS; t++) begin
            if (32'(dec_value) >= t * 10) begin
                tens_digit = 4'(t);
                ones_digit = 4'(32'(dec_value) - t * 10);
            end
        end
    end

    seg7_decoder u_seg_tens (
        .digit_i (tens_digit),
        .seg_o   (hex_tens)
    );

    seg7_decoder u_seg_ones (
        .digit_i (ones_digit),
        .seg_o   (hex_ones)
    );

    seg7_decoder u_seg_code (
        .digit_i (code_in),
        .seg_o   (hex_code)
    );

endmodule

// File: tb/tb_card_draw_hex.sv
module tb_card_draw_hex;

    logic       clock;
    logic       reset;
    logic       draw;
    logic [3:0] card;
    logic [5:0] dec_value;
    logic [6:0] hex_tens;
    logic [6:0] hex_ones;
    logic [3:0] code_in;
    logic [6:0] hex_code;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int cnt_m;
    int card_m;
    bit prev_m;

    logic [6:0] seg_tbl [16];

    card_draw_hex dut (
        .clock     (clock),
        .reset     (reset),
        .draw      (draw),
        .card      (card),
        .dec_value (dec_value),
        .hex_tens  (hex_tens),
        .hex_ones  (hex_ones),
        .code_in   (code_in),
        .hex_code  (hex_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, advance the model by the behavioural
    // rules, then sample the DUT 1 time unit after the edge.
    task automatic cyc(input logic d, input logic r);
        draw  = d;
        reset = r;
        @(posedge clock);
        if (r) begin
            cnt_m  = 1;
            card_m = 0;
            prev_m = 0;
        end else begin
            if (d && !prev_m) card_m = cnt_m;
            if (!d) cnt_m = (cnt_m % 13) + 1;
            prev_m = d;
        end
        #1;
        check("card", 32'(card), card_m);
        check("cnt", 32'(dut.cnt_q), cnt_m);
        checks++;
        assert (card == 0 || (card >= 1 && card <= 13))
        else begin
            errors++;
            $error("FAIL card_range observed=%0d expected=0..13", card);
        end
    endtask

    task automatic check_dec(input int v);
        dec_value = 6'(v);
        #1;
        check("hex_tens", 32'(hex_tens), 32'(seg_tbl[v / 10]));
        check("hex_ones", 32'(hex_ones), 32'(seg_tbl[v % 10]));
    endtask

    initial begin
        seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        cnt_m     = 1;
        card_m    = 0;
        prev_m    = 0;
        draw      = 1'b0;
        reset     = 1'b1;
        dec_value = 6'd0;
        code_in   = 4'd0;

        // Reset for two cycles
        cyc(0, 1);
        cyc(0, 1);
        check("reset_card", 32'(card), 0);
        check("reset_cnt", 32'(dut.cnt_q), 1);
        check("dec0_tens", 32'(hex_tens), 32'(7'b1000000));
        check("dec0_ones", 32'(hex_ones), 32'(7'b1000000));

        // Counter wrap: 13 low cycles, back to 1
        for (int i = 0; i < 13; i++) cyc(0, 0);
        check("wrap_cnt", 32'(dut.cnt_q), 1);

        // Single draw at cnt=7, held 5 cycles
        for (int i = 0; i < 20 && cnt_m != 7; i++) cyc(0, 0);
        check("pre_draw_cnt", 32'(cnt_m), 7);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0);
            check("held_card", 32'(card), 7);
        end
        cyc(0, 0);
        check("resume_cnt", 32'(dut.cnt_q), 8);

        // Repeat draws at 13 and 2
        for (int i = 0; i < 20 && cnt_m != 13; i++) cyc(0, 0);
        cyc(1, 0);
        check("draw13", 32'(card), 13);
        cyc(0, 0);
        for (int i = 0; i < 20 && cnt_m != 2; i++) cyc(0, 0);
        cyc(1, 0);
        check("draw2", 32'(card), 2);
        cyc(0, 0);

        // Reset together with a draw rising edge
        cyc(1, 1);
        check("rst_draw_card", 32'(card), 0);
        cyc(0, 0);
        cyc(0, 0);

        // Draw held across reset release: one load on first post-reset cycle
        cyc(1, 0);
        cyc(1, 1);
        check("mid_rst_card", 32'(card), 0);
        cyc(1, 0);
        check("post_rst_load", 32'(card), 1);
        cyc(1, 0);
        check("post_rst_hold", 32'(card), 1);
        cyc(0, 0);

        // Randomised draw/reset traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic d, r;
            d = ($urandom_range(0, 2) == 0) ? ~draw : draw;
            r = ($urandom_range(0, 39) == 0);
            cyc(d, r);
        end

        // Decimal display: named cases then full sweep
        dec_value = 6'd21; #1;
        check("d21_tens", 32'(hex_tens), 32'(7'b0100100));
        check("d21_ones", 32'(hex_ones), 32'(7'b1111001));
        dec_value = 6'd34; #1;
        check("d34_tens", 32'(hex_tens), 32'(7'b0110000));
        check("d34_ones", 32'(hex_ones), 32'(7'b0011001));
        dec_value = 6'd63; #1;
        check("d63_tens", 32'(hex_tens), 32'(7'b0000010));
        check("d63_ones", 32'(hex_ones), 32'(7'b0110000));
        dec_value = 6'd9; #1;
        check("d9_tens", 32'(hex_tens), 32'(7'b1000000));
        check("d9_ones", 32'(hex_ones), 32'(7'b0010000));
        for (int v = 0; v < 64; v++) check_dec(v);
        for (int i = 0; i < 20; i++) check_dec(int'($urandom_range(0, 63)));

        // Hex code: A, d, E then sweep
        code_in = 4'hA; #1;
        check("code_A", 32'(hex_code), 32'(7'b0001000));
        code_in = 4'hD; #1;
        check("code_d", 32'(hex_code), 32'(7'b0100001));
        code_in = 4'hE; #1;
        check("code_E", 32'(hex_code), 32'(7'b0000110));
        for (int c = 0; c < 16; c++) begin
            code_in = 4'(c);
            #1;
            check("code_sweep", 32'(hex_code), 32'(seg_tbl[c]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
